framed_shiftregister: RTL and testbench

Parametrised successor to the fixed 8-bit test shift register.
- Serial-in/serial-out shift register with parallel load, selectable bit order and frame counting.
- Completed frames are captured into a hold register.
- The held frame is shown on the board LEDs one page (LED_W bits) at a time, with page stepping.
- Sits between the input conditioners (edge strobes) and the LED outputs in the board test wrapper.

---
 rtl/framed_shiftregister_pkg.sv | 16 +
 rtl/framed_shiftregister_led_page_mux.sv | 29 ++
 rtl/framed_shiftregister.sv | 142 ++++++++++++++
 tb/tb_framed_shiftregister.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/framed_shiftregister_pkg.sv
// Shared types and sizing helpers for the framed shift register.
package fsr_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_e;

  function automatic int fsr_clog2_min1(input int v);
    int r;
    r = $clog2(v);
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int fsr_num_pages(input int w, input int l);
    return (w + l - 1) / l;
  endfunction

endpackage

// File: rtl/framed_shiftregister_led_page_mux.sv
// Page selector: zero-pads the held frame to whole LED pages and picks one page.
module led_page_mux
  import fsr_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int LED_W     = 4,
  parameter int NUM_PAGES = 2,
  parameter int PAGE_W    = 1
) (
  input  logic [WIDTH-1:0]  frame_i,
  input  logic [PAGE_W-1:0] page_i,
  output logic [LED_W-1:0]  led_o
);

  logic [NUM_PAGES*LED_W-1:0] padded;

  always_comb begin
    padded = '0;
    padded[WIDTH-1:0] = frame_i;
  end

  // Loop compare keeps every part-select in range when NUM_PAGES is not a power of two.
  always_comb begin
    led_o = '0;
    for (int p = 0; p < NUM_PAGES; p++)
      if (int'(page_i) == p) led_o = padded[p*LED_W +: LED_W];
  end

endmodule

// File: rtl/framed_shiftregister.sv
// Serial/parallel shift register with frame capture and paged LED view.
// FRAME_PARITY_EN adds a trailing even-parity bit per frame and the parity_err output.
module framed_shiftregister
  import fsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LED_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  input  logic                 periph_edge,
  input  logic                 parallel_load,
  input  logic [WIDTH-1:0]     parallel_in,
  input  logic                 msb_first,
  input  logic                 page_next,
  output logic [WIDTH-1:0]     parallel_out,
  output logic                 serial_out,
  output logic [WIDTH-1:0]     frame_out,
  output logic                 frame_done,
  output logic [fsr_clog2_min1(WIDTH+1)-1:0] bit_count,
  output logic [fsr_clog2_min1(fsr_num_pages(WIDTH, LED_W))-1:0] page,
`ifdef FRAME_PARITY_EN
  output logic                 parity_err,
`endif
  output logic [LED_W-1:0]     led
);

  localparam int NUM_PAGES = fsr_num_pages(WIDTH, LED_W);
  localparam int CNT_W     = fsr_clog2_min1(WIDTH + 1);
  localparam int PAGE_W    = fsr_clog2_min1(NUM_PAGES);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sr_q, sr_d, frame_q, frame_d, shifted;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAGE_W-1:0]  page_q, page_d;
  logic               order_q, order_d, eff_order;
  logic               done_q, done_d;
`ifdef FRAME_PARITY_EN
  logic               perr_q, perr_d;
`endif

  // A strobe in IDLE starts a new frame, so it uses the live pin rather than the latch.
  assign eff_order = (state_q == IDLE) ? msb_first : order_q;
  assign shifted   = eff_order ? {sr_q[WIDTH-2:0], serial_in} : {serial_in, sr_q[WIDTH-1:1]};

  always_comb begin
    sr_d    = sr_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    order_d = order_q;
    done_d  = 1'b0;
`ifdef FRAME_PARITY_EN
    perr_d  = perr_q;
`endif
    if (parallel_load) begin
      sr_d    = parallel_in;
      cnt_d   = '0;
      state_d = IDLE;
      order_d = msb_first;
    end else if (periph_edge) begin
`ifdef FRAME_PARITY_EN
      if (state_q == PARITY) begin
        frame_d = sr_q;
        perr_d  = (^sr_q) ^ serial_in;
        done_d  = 1'b1;
        cnt_d   = '0;
        state_d = IDLE;
      end else
`endif
      begin
        order_d = eff_order;
        sr_d    = shifted;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef FRAME_PARITY_EN
          cnt_d   = CNT_W'(WIDTH);
          state_d = PARITY;
`else
          frame_d = shifted;
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
`endif
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = SHIFT;
        end
      end
    end
  end

  always_comb begin
    page_d = page_q;
    if (page_next) page_d = (int'(page_q) == NUM_PAGES - 1) ? '0 : page_q + PAGE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      frame_q <= '0;
      cnt_q   <= '0;
      page_q  <= '0;
      order_q <= 1'b1;
      done_q  <= 1'b0;
`ifdef FRAME_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      page_q  <= page_d;
      order_q <= order_d;
      done_q  <= done_d;
`ifdef FRAME_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  assign parallel_out = sr_q;
  assign serial_out   = order_q ? sr_q[WIDTH-1] : sr_q[0];
  assign frame_out    = frame_q;
  assign frame_done   = done_q;
  assign bit_count    = cnt_q;
  assign page         = page_q;
`ifdef FRAME_PARITY_EN
  assign parity_err   = perr_q;
`endif

  led_page_mux #(
    .WIDTH(WIDTH), .LED_W(LED_W), .NUM_PAGES(NUM_PAGES), .PAGE_W(PAGE_W)
  ) u_led_mux (
    .frame_i(frame_q),
    .page_i (page_q),
    .led_o  (led)
  );

endmodule

// File: tb/tb_framed_shiftregister.sv
// Directed bench: an 8-bit/4-LED instance plus a 12-bit/4-LED instance for page coverage.
module tb_framed_shiftregister;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       serial_in = 0, periph_edge = 0, parallel_load = 0, msb_first = 1, page_next = 0;
  logic [7:0] parallel_in = '0;
  logic [7:0] parallel_out, frame_out;
  logic       serial_out, frame_done;
  logic [3:0] bit_count, led;
  logic [0:0] page;
`ifdef FRAME_PARITY_EN
  logic       parity_err;
`endif

  logic        b_sin = 0, b_edge = 0, b_load = 0, b_msb = 1, b_pnext = 0;
  logic [11:0] b_pin = '0, b_pout, b_frame;
  logic        b_sout, b_done;
  logic [3:0]  b_cnt, b_led;
  logic [1:0]  b_page;
`ifdef FRAME_PARITY_EN
  logic        b_perr;
`endif

  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  framed_shiftregister #(.WIDTH(8), .LED_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .periph_edge(periph_edge),
    .parallel_load(parallel_load), .parallel_in(parallel_in), .msb_first(msb_first),
    .page_next(page_next), .parallel_out(parallel_out), .serial_out(serial_out),
    .frame_out(frame_out), .frame_done(frame_done), .bit_count(bit_count), .page(page),
`ifdef FRAME_PARITY_EN
    .parity_err(parity_err),
`endif
    .led(led)
  );

  framed_shiftregister #(.WIDTH(12), .LED_W(4)) dut12 (
    .clk(clk), .rst_n(rst_n), .serial_in(b_sin), .periph_edge(b_edge),
    .parallel_load(b_load), .parallel_in(b_pin), .msb_first(b_msb),
    .page_next(b_pnext), .parallel_out(b_pout), .serial_out(b_sout),
    .frame_out(b_frame), .frame_done(b_done), .bit_count(b_cnt), .page(b_page),
`ifdef FRAME_PARITY_EN
    .parity_err(b_perr),
`endif
    .led(b_led)
  );

  // Stimulus helpers; each returns at the falling edge right after the strobed rising edge.
  task automatic strobe(input logic b);
    @(negedge clk); serial_in = b; periph_edge = 1'b1;
    @(negedge clk); periph_edge = 1'b0;
  endtask

  task automatic load(input logic [7:0] v, input logic m);
    @(negedge clk); parallel_in = v; msb_first = m; parallel_load = 1'b1;
    @(negedge clk); parallel_load = 1'b0;
  endtask

  task automatic pnext();
    @(negedge clk); page_next = 1'b1;
    @(negedge clk); page_next = 1'b0;
  endtask

  task automatic close_frame(input logic p);
`ifdef FRAME_PARITY_EN
    strobe(p);
`endif
  endtask

  task automatic b_strobe(input logic b);
    @(negedge clk); b_sin = b; b_edge = 1'b1;
    @(negedge clk); b_edge = 1'b0;
  endtask

  task automatic b_pnext_t();
    @(negedge clk); b_pnext = 1'b1;
    @(negedge clk); b_pnext = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (parallel_out !== 8'h00) $display("FAIL reset_pout got %h exp 00", parallel_out); else pass_cnt++;
    total_cnt++; if (frame_out !== 8'h00) $display("FAIL reset_frame got %h exp 00", frame_out); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_done got %b exp 0", frame_done); else pass_cnt++;
    total_cnt++; if (bit_count !== 4'd0) $display("FAIL reset_cnt got %0d exp 0", bit_count); else pass_cnt++;
    total_cnt++; if (page !== 1'b0 || led !== 4'h0) $display("FAIL reset_page got %b/%h exp 0/0", page, led); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_msb_shift();
    logic [7:0] exp_so;
    int ndone;
    exp_so = 8'hA5;
    ndone = 0;
    load(8'hA5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (serial_out !== exp_so[7-i]) $display("FAIL msb_serial_out[%0d] got %b exp %b", i, serial_out, exp_so[7-i]);
      else pass_cnt++;
      strobe(1'b0);
      if (i < 7 && frame_done) ndone++;
    end
    close_frame(1'b0);
    total_cnt++; if (ndone != 0) $display("FAIL msb_early_done got %0d exp 0", ndone); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL msb_done got %b exp 1", frame_done); else pass_cnt++;
    total_cnt++; if (frame_out !== 8'h00) $display("FAIL msb_frame got %h exp 00", frame_out); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL msb_done_width got %b exp 0", frame_done); else pass_cnt++;
  endtask

  task automatic test_lsb_and_pages();
    logic [7:0] bits;
    bits = 8'b0011_1100;
    msb_first = 1'b0;
    for (int i = 0; i < 8; i++) begin
      strobe(bits[i]);
      if (i == 2) begin
        total_cnt++; if (bit_count !== 4'd3) $display("FAIL lsb_midcount got %0d exp 3", bit_count); else pass_cnt++;
      end
    end
    close_frame(1'b0);
    total_cnt++; if (frame_done !== 1'b1) $display("FAIL lsb_done got %b exp 1", frame_done); else pass_cnt++;
    total_cnt++; if (frame_out !== 8'h3C) $display("FAIL lsb_frame got %h exp 3c", frame_out); else pass_cnt++;
    total_cnt++; if (led !== 4'hC) $display("FAIL led_page0 got %h exp c", led); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (frame_done !== 1'b0) $display("FAIL lsb_done_width got %b exp 0", frame_done); else pass_cnt++;
    pnext();
    total_cnt++; if (page !== 1'b1 || led !== 4'h3) $display("FAIL led_page1 got %b/%h exp 1/3", page, led); else pass_cnt++;
    pnext();
    total_cnt++; if (page !== 1'b0 || led !== 4'hC) $display("FAIL page_wrap got %b/%h exp 0/c", page, led); else pass_cnt++;
  endtask

  task automatic test_load_vs_shift();
    strobe(1'b1);
    total_cnt++; if (bit_count !== 4'd1) $display("FAIL pre_load_cnt got %0d exp 1", bit_count); else pass_cnt++;
    @(negedge clk); parallel_in = 8'h5A; parallel_load = 1'b1; periph_edge = 1'b1; serial_in = 1'b1;
    @(negedge clk); parallel_load = 1'b0; periph_edge = 1'b0;
    total_cnt++; if (parallel_out !== 8'h5A) $display("FAIL load_wins_pout got %h exp 5a", parallel_out); else pass_cnt++;
    total_cnt++; if (bit_count !== 4'd0) $display("FAIL load_wins_cnt got %0d exp 0", bit_count); else pass_cnt++;
    total_cnt++; if (frame_done !== 1'b0 || frame_out !== 8'h3C) $display("FAIL load_keeps_frame got %b/%h exp 0/3c", frame_done, frame_out); else pass_cnt++;
  endtask

  task automatic test_async_reset();
    int ndone;
    ndone = 0;
    pnext();
    for (int i = 0; i < 5; i++) strobe(1'b1);
    total_cnt++; if (bit_count !== 4'd5) $display("FAIL pre_rst_cnt got %0d exp 5", bit_count); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (parallel_out !== 8'h00 || serial_out !== 1'b0) $display("FAIL async_rst_sr got %h/%b exp 00/0", parallel_out, serial_out); else pass_cnt++;
    total_cnt++; if (frame_out !== 8'h00 || led !== 4'h0) $display("FAIL async_rst_frame got %h/%h exp 00/0", frame_out, led); else pass_cnt++;
    total_cnt++; if (bit_count !== 4'd0 || page !== 1'b0) $display("FAIL async_rst_cnt got %0d/%b exp 0/0", bit_count, page); else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      strobe(1'b1);
      if (frame_done) ndone++;
    end
    repeat (2) begin @(negedge clk); if (frame_done) ndone++; end
    total_cnt++; if (ndone != 0) $display("FAIL post_rst_done got %0d exp 0", ndone); else pass_cnt++;
    total_cnt++; if (bit_count !== 4'd3) $display("FAIL post_rst_cnt got %0d exp 3", bit_count); else pass_cnt++;
  endtask

  task automatic test_order_latch();
    logic [11:0] v;
    logic [4:0]  tail;
    tail = 5'b00001;
    load(8'h00, 1'b1);
    for (int i = 0; i < 3; i++) strobe(1'b1);
    msb_first = 1'b0;
    @(negedge clk);
    total_cnt++; if (serial_out !== 1'b0) $display("FAIL order_serial_out got %b exp 0", serial_out); else pass_cnt++;
    for (int i = 4; i >= 0; i--) strobe(tail[i]);
    close_frame(1'b0);
    total_cnt++; if (frame_out !== 8'hE1) $display("FAIL order_held got %h exp e1", frame_out); else pass_cnt++;
    strobe(1'b1); strobe(1'b1);
    for (int i = 0; i < 6; i++) strobe(1'b0);
    close_frame(1'b0);
    total_cnt++; if (frame_out !== 8'h03) $display("FAIL order_next_frame got %h exp 03", frame_out); else pass_cnt++;

    v = 12'hABC;
    for (int i = 11; i >= 0; i--) b_strobe(v[i]);
`ifdef FRAME_PARITY_EN
    b_strobe(1'b1);
`endif
    total_cnt++; if (b_frame !== 12'hABC || b_done !== 1'b1) $display("FAIL w12_frame got %h/%b exp abc/1", b_frame, b_done); else pass_cnt++;
    total_cnt++; if (b_led !== 4'hC) $display("FAIL w12_page0 got %h exp c", b_led); else pass_cnt++;
    b_pnext_t();
    total_cnt++; if (b_led !== 4'hB) $display("FAIL w12_page1 got %h exp b", b_led); else pass_cnt++;
    b_pnext_t();
    total_cnt++; if (b_page !== 2'd2 || b_led !== 4'hA) $display("FAIL w12_page2 got %0d/%h exp 2/a", b_page, b_led); else pass_cnt++;
    b_pnext_t();
    total_cnt++; if (b_page !== 2'd0 || b_led !== 4'hC) $display("FAIL w12_wrap got %0d/%h exp 0/c", b_page, b_led); else pass_cnt++;
  endtask

`ifdef FRAME_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    for (int r = 0; r < 2; r++) begin
      d = 8'hA5;
      msb_first = 1'b1;
      for (int i = 7; i >= 0; i--) strobe(d[i]);
      total_cnt++; if (frame_done !== 1'b0 || bit_count !== 4'd8) $display("FAIL par_wait[%0d] got %b/%0d exp 0/8", r, frame_done, bit_count); else pass_cnt++;
      strobe(r[0]);
      total_cnt++; if (frame_done !== 1'b1 || frame_out !== 8'hA5) $display("FAIL par_done[%0d] got %b/%h exp 1/a5", r, frame_done, frame_out); else pass_cnt++;
      total_cnt++; if (parity_err !== r[0]) $display("FAIL par_err[%0d] got %b exp %b", r, parity_err, r[0]); else pass_cnt++;
    end
    d = 8'h0F;
    for (int i = 7; i >= 0; i--) strobe(d[i]);
    load(8'h11, 1'b1);
    total_cnt++; if (frame_done !== 1'b0 || parity_err !== 1'b1 || frame_out !== 8'hA5) $display("FAIL par_abort got %b/%b/%h exp 0/1/a5", frame_done, parity_err, frame_out); else pass_cnt++;
  endtask
`endif

  initial begin
    test_reset();
    test_msb_shift();
    test_lsb_and_pages();
    test_load_vs_shift();
    test_async_reset();
    test_order_latch();
`ifdef FRAME_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
